// File: rtl/ones_comp_seq_div.sv
// ones_comp_seq_div: multi-cycle ones'-complement divider.
//
// Divides a 30-bit AGC double-precision dividend by a 15-bit
// ones'-complement divisor, giving a 15-bit quotient and a 15-bit remainder.
// The core performs restoring division on 14-bit magnitudes and resolves
// ITER_PER_CYCLE quotient bits per ITERATE cycle. ITER_PER_CYCLE must divide
// 14, so the legal values are 1, 2, 7 and 14.
//
// Optional build macro ONES_COMP_DIV_ZERO_BYPASS_EN: when it is defined, an
// error-free zero dividend skips ITERATE and reaches FINISH directly.
//
// Handshake: start is sampled only while the block is IDLE, and the operands
// are captured on that same edge. busy stays high from the next cycle through
// FINISH. done is a one-cycle pulse in the cycle after FINISH. quot, remain
// and div_error are valid while done is high and hold until the next FINISH
// or reset.
module ones_comp_seq_div #(
   parameter int ITER_PER_CYCLE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [29:0] numer,
   input  logic [14:0] denom,
   output logic        busy,
   output logic        done,
   output logic [14:0] quot,
   output logic [14:0] remain,
   output logic        div_error
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ITERATE = 2'd2,
      FINISH  = 2'd3
   } state_t;

   // The bit counter value at which the final group of quotient bits resolves.
   localparam logic [3:0] LAST_CNT = 4'(14 - ITER_PER_CYCLE);
   localparam logic [3:0] STEP_CNT = 4'(ITER_PER_CYCLE);

   state_t      state;

   // Operands captured when start is accepted.
   logic [29:0] numer_q;
   logic [14:0] denom_q;

   // Division working registers.
   logic [13:0] rem_q;     // partial remainder; always below dm_q between steps
   logic [13:0] lo_q;      // dividend bits that have not been consumed, MSB first
   logic [13:0] quo_q;     // quotient bits resolved so far
   logic [13:0] dm_q;      // divisor magnitude
   logic        sn_q;      // dividend sign, which the remainder also takes
   logic        sq_q;      // quotient sign
   logic        err_q;     // divide-by-zero or quotient overflow
   logic [3:0]  bit_cnt;   // quotient bits already resolved

   // SETUP decode: magnitudes, signs and the error decision.
   logic [13:0] hm;
   logic [13:0] lm;
   logic [13:0] dm;
   logic        hi_nz;
   logic        lo_nz;
   logic        opp_sign;
   logic        sn;
   logic        sq;
   logic        err;
   logic [27:0] n_mag;
`ifdef ONES_COMP_DIV_ZERO_BYPASS_EN
   logic        n_zero;
`endif

   // Decode the captured operands into magnitudes and signs, and detect errors.
   always_comb begin
      hm       = numer_q[29] ? ~numer_q[28:15] : numer_q[28:15];
      lm       = numer_q[14] ? ~numer_q[13:0]  : numer_q[13:0];
      dm       = denom_q[14] ? ~denom_q[13:0]  : denom_q[13:0];
      hi_nz    = (hm != 14'd0);
      lo_nz    = (lm != 14'd0);
      // Both +0 and -0 count as zero, so a zero word contributes no sign.
      if (hi_nz) begin
         sn = numer_q[29];
      end else if (lo_nz) begin
         sn = numer_q[14];
      end else begin
         sn = 1'b0;
      end
      opp_sign = hi_nz && lo_nz && (numer_q[29] != numer_q[14]);
      // With opposite signs the low word reduces the high word. Hm is at least
      // 1 and Lm is below 2^14, so the difference never goes negative.
      if (opp_sign) begin
         n_mag = {hm, 14'd0} - {14'd0, lm};
      end else begin
         n_mag = {hm, lm};
      end
      sq  = sn ^ denom_q[14];
      // The quotient overflows 14 bits when the upper half of N reaches Dm.
      err = (dm == 14'd0) || (n_mag[27:14] >= dm);
`ifdef ONES_COMP_DIV_ZERO_BYPASS_EN
      n_zero = (n_mag == 28'd0);
`endif
   end

   // ITERATE datapath: one restoring-division step for each quotient bit.
   logic [13:0] rem_it;
   logic [13:0] lo_it;
   logic [13:0] quo_it;
   logic [14:0] rem_sh;

   // Resolve ITER_PER_CYCLE quotient bits, MSB first, from the registered state.
   always_comb begin
      rem_it = rem_q;
      lo_it  = lo_q;
      quo_it = quo_q;
      rem_sh = 15'd0;
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
         // R' = 2R + next bit, which is below 2*Dm and so needs 15 bits.
         // After the subtract, R is below Dm again and fits in 14 bits.
         rem_sh = {rem_it, lo_it[13]};
         lo_it  = {lo_it[12:0], 1'b0};
         if (rem_sh >= {1'b0, dm_q}) begin
            rem_it = 14'(rem_sh - {1'b0, dm_q});
            quo_it = {quo_it[12:0], 1'b1};
         end else begin
            rem_it = rem_sh[13:0];
            quo_it = {quo_it[12:0], 1'b0};
         end
      end
   end

   // Control FSM plus the registered datapath and outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quot      <= 15'o00000;
         remain    <= 15'o00000;
         div_error <= 1'b0;
         numer_q   <= 30'd0;
         denom_q   <= 15'd0;
         rem_q     <= 14'd0;
         lo_q      <= 14'd0;
         quo_q     <= 14'd0;
         dm_q      <= 14'd0;
         sn_q      <= 1'b0;
         sq_q      <= 1'b0;
         err_q     <= 1'b0;
         bit_cnt   <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  numer_q <= numer;
                  denom_q <= denom;
                  busy    <= 1'b1;
                  state   <= SETUP;
               end
            end

            SETUP: begin
               sn_q    <= sn;
               sq_q    <= sq;
               err_q   <= err;
               dm_q    <= dm;
               rem_q   <= n_mag[27:14];
               lo_q    <= n_mag[13:0];
               quo_q   <= 14'd0;
               bit_cnt <= 4'd0;
               if (err) begin
                  state <= FINISH;
`ifdef ONES_COMP_DIV_ZERO_BYPASS_EN
               end else if (n_zero) begin
                  // A zero dividend gives Q=0 and R=0. Those values are already
                  // loaded above, so FINISH can produce the result directly.
                  state <= FINISH;
`endif
               end else begin
                  state <= ITERATE;
               end
            end

            ITERATE: begin
               rem_q   <= rem_it;
               lo_q    <= lo_it;
               quo_q   <= quo_it;
               bit_cnt <= bit_cnt + STEP_CNT;
               if (bit_cnt == LAST_CNT) begin
                  state <= FINISH;
               end
            end

            FINISH: begin
               if (err_q) begin
                  // Saturate to the largest magnitude that carries the quotient sign.
                  quot      <= sq_q ? 15'o40000 : 15'o37777;
                  remain    <= 15'o00000;
                  div_error <= 1'b1;
               end else begin
                  // Signs are applied even to zero magnitudes, so -0 results can appear.
                  quot      <= sq_q ? {1'b1, ~quo_q} : {1'b0, quo_q};
                  remain    <= sn_q ? {1'b1, ~rem_q} : {1'b0, rem_q};
                  div_error <= 1'b0;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ones_comp_seq_div.sv
// tb_ones_comp_seq_div: bench for ones_comp_seq_div.
// Two instances share one stimulus stream, one with ITER_PER_CYCLE=1 and one
// with ITER_PER_CYCLE=2. A transaction-level model computes the signed integer
// division for each accepted start and predicts busy, done and the result
// outputs on every cycle. Directed operations also pin the results and the
// latencies to hand-computed constants.
module tb_ones_comp_seq_div;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [29:0] numer;
   logic [14:0] denom;

   logic        busy1, done1, err1;
   logic [14:0] quot1, remain1;
   logic        busy2, done2, err2;
   logic [14:0] quot2, remain2;

   int edge_cnt = 0;
   int checks   = 0;
   int errors   = 0;

`ifdef ONES_COMP_DIV_ZERO_BYPASS_EN
   localparam int ZLAT1 = 2;
   localparam int ZLAT2 = 2;
`else
   localparam int ZLAT1 = 16;
   localparam int ZLAT2 = 9;
`endif

   ones_comp_seq_div #(.ITER_PER_CYCLE(1)) dut1 (
      .clock(clock), .reset(reset), .start(start), .numer(numer), .denom(denom),
      .busy(busy1), .done(done1), .quot(quot1), .remain(remain1), .div_error(err1)
   );

   ones_comp_seq_div #(.ITER_PER_CYCLE(2)) dut2 (
      .clock(clock), .reset(reset), .start(start), .numer(numer), .denom(denom),
      .busy(busy2), .done(done2), .quot(quot2), .remain(remain2), .div_error(err2)
   );

   // Clock and edge counter.
   always #5 clock = ~clock;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   // ---------------------------------------------------------------- helpers
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
      end
   endtask

   function automatic int oc_val(input logic [14:0] w);
      logic [13:0] m;
      m = w[14] ? ~w[13:0] : w[13:0];
      return w[14] ? -int'(m) : int'(m);
   endfunction

   function automatic logic [14:0] ow(input bit s, input logic [13:0] m);
      return s ? {1'b1, ~m} : {1'b0, m};
   endfunction

   // Reference: take the signed value of the dividend, divide by integer
   // arithmetic, then re-encode the results in ones' complement.
   function automatic void ref_div(input logic [29:0] n, input logic [14:0] d, input int iter,
                                   output logic [14:0] q, output logic [14:0] r,
                                   output logic e, output int lat);
      int  v, nmag, dmag, qi, ri;
      bit  sn, sq;
      v    = oc_val(n[29:15]) * 16384 + oc_val(n[14:0]);
      sn   = (v < 0);
      nmag = sn ? -v : v;
      dmag = oc_val(d);
      if (dmag < 0) dmag = -dmag;
      sq   = sn ^ d[14];
      e    = (dmag == 0) || ((nmag / dmag) > 16383);
      if (e) begin
         q   = sq ? 15'o40000 : 15'o37777;
         r   = 15'o00000;
         lat = 2;
      end else begin
         qi  = nmag / dmag;
         ri  = nmag % dmag;
         q   = sq ? (15'h7fff ^ 15'(qi)) : 15'(qi);
         r   = sn ? (15'h7fff ^ 15'(ri)) : 15'(ri);
         lat = 2 + 14 / iter;
`ifdef ONES_COMP_DIV_ZERO_BYPASS_EN
         if (nmag == 0) lat = 2;
`endif
      end
   endfunction

   // ---------------------------------------------------------------- model
   int          pend[2];
   logic [14:0] pq[2], pr[2], hq[2], hr[2];
   logic        pe[2], he[2], xd[2], xb[2];

   task automatic model_edge(input int k);
      bit idle;
      if (reset) begin
         pend[k] = 0; hq[k] = '0; hr[k] = '0; he[k] = 1'b0; xd[k] = 1'b0; xb[k] = 1'b0;
      end else begin
         idle  = (pend[k] == 0);
         xd[k] = 1'b0;
         if (pend[k] > 0) begin
            pend[k]--;
            if (pend[k] == 0) begin
               xd[k] = 1'b1; hq[k] = pq[k]; hr[k] = pr[k]; he[k] = pe[k];
            end
         end
         if (idle && start) begin
            ref_div(numer, denom, (k == 0) ? 1 : 2, pq[k], pr[k], pe[k], pend[k]);
         end
         xb[k] = (pend[k] > 0);
      end
   endtask

   // Compare process: advance the model on each rising edge, then check both
   // instances on the falling edge that follows.
   initial begin : compare
      for (int k = 0; k < 2; k++) begin
         pend[k] = 0; xd[k] = 1'b0; xb[k] = 1'b0; he[k] = 1'b0; hq[k] = '0; hr[k] = '0;
      end
      forever begin
         @(posedge clock);
         for (int k = 0; k < 2; k++) model_edge(k);
         @(negedge clock);
         chk("busy1", busy1, xb[0]);
         chk("done1", done1, xd[0]);
         chk("quot1", quot1, hq[0]);
         chk("remain1", remain1, hr[0]);
         chk("err1", err1, he[0]);
         chk("busy2", busy2, xb[1]);
         chk("done2", done2, xd[1]);
         chk("quot2", quot2, hq[1]);
         chk("remain2", remain2, hr[1]);
         chk("err2", err2, he[1]);
      end
   end

   // ---------------------------------------------------------------- driver
   // Called at a falling edge. Issues a start, waits for done from both
   // instances, then checks the literal results and both latencies. It returns
   // at the falling edge of dut1's done cycle, so a following call starts
   // back-to-back with this operation.
   task automatic run_op(input string nm, input logic [29:0] n, input logic [14:0] d,
                         input logic [14:0] eq, input logic [14:0] er, input logic ee,
                         input int elat, input int elat2, input int glitch_at);
      int t0, t2, waited;
      start = 1'b1; numer = n; denom = d;
      @(negedge clock);
      start  = 1'b0;
      t0     = edge_cnt;
      t2     = -1;
      waited = 0;
      while (waited < 200) begin
         if (done2 === 1'b1 && t2 < 0) t2 = edge_cnt;
         if (done1 === 1'b1) break;
         if (glitch_at > 0 && waited == glitch_at) begin
            start = 1'b1; numer = 30'($urandom); denom = 15'($urandom_range(1, 32766));
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         waited++;
      end
      start = 1'b0;
      if (waited >= 200) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no done within 200 cycles", nm);
      end else begin
         chk({nm, "_lat1"}, edge_cnt - t0, elat);
         chk({nm, "_lat2"}, t2 - t0, elat2);
         chk({nm, "_quot"}, quot1, eq);
         chk({nm, "_remain"}, remain1, er);
         chk({nm, "_err"}, err1, ee);
      end
   endtask

   task automatic rand_ops(output logic [29:0] n, output logic [14:0] d);
      int          kind, dmag, hmag;
      logic [13:0] lm;
      kind = $urandom_range(0, 9);
      dmag = $urandom_range(1, 16383);
      if (kind == 3) dmag = $urandom_range(1, 3);
      hmag = (kind == 0) ? $urandom_range(0, 16383) : $urandom_range(0, dmag - 1);
      lm   = 14'($urandom);
      if (kind == 1) begin hmag = 0; lm = 14'd0; end
      if (kind == 2) dmag = 0;
      n = {ow(1'($urandom), 14'(hmag)), ow(1'($urandom), lm)};
      d = ow(1'($urandom), 14'(dmag));
   endtask

   initial begin : driver
      bit          saw_done;
      logic [29:0] rn;
      logic [14:0] rd;
      reset = 1'b1; start = 1'b0; numer = '0; denom = '0;
      repeat (3) @(negedge clock);
      chk("reset_busy", busy1, 1'b0);
      chk("reset_quot", quot1, 15'o00000);
      reset = 1'b0;

      // Directed operations run back-to-back: each start falls in the previous done cycle.
      run_op("pos100_div7", {15'o00000, 15'o00144}, 15'o00007, 15'o00016, 15'o00002, 1'b0, 16, 9, 0);
      run_op("neg100_div7", {15'o77777, 15'o77633}, 15'o00007, 15'o77761, 15'o77775, 1'b0, 16, 9, 0);
      run_op("2p14_div3",   {15'o00001, 15'o00000}, 15'o00003, 15'o12525, 15'o00001, 1'b0, 16, 9, 0);
      run_op("mixed_divm3", {15'o00001, 15'o77776}, 15'o77774, 15'o65252, 15'o00000, 1'b0, 16, 9, 0);
      run_op("div_zero",    {15'o00000, 15'o00144}, 15'o00000, 15'o37777, 15'o00000, 1'b1, 2, 2, 0);
      run_op("ovf_pos",     {15'o00005, 15'o00000}, 15'o00005, 15'o37777, 15'o00000, 1'b1, 2, 2, 0);
      run_op("ovf_neg",     {15'o77772, 15'o00000}, 15'o00005, 15'o40000, 15'o00000, 1'b1, 2, 2, 0);
      run_op("max_hi",      {15'o00006, 15'o77777}, 15'o00007, 15'o33333, 15'o00003, 1'b0, 16, 9, 0);
      run_op("zero_divm7",  {15'o77777, 15'o00000}, 15'o77770, 15'o77777, 15'o00000, 1'b0, ZLAT1, ZLAT2, 0);
      // A second start pulsed mid-ITERATE must be ignored.
      run_op("glitch",      {15'o00000, 15'o00144}, 15'o00007, 15'o00016, 15'o00002, 1'b0, 16, 9, 5);

      // Reset during iteration: busy drops, outputs clear, and no done appears.
      start = 1'b1; numer = {15'o00001, 15'o00000}; denom = 15'o00003;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy1", busy1, 1'b0);
      chk("abort_busy2", busy2, 1'b0);
      chk("abort_quot", quot1, 15'o00000);
      chk("abort_remain", remain1, 15'o00000);
      chk("abort_err", err1, 1'b0);
      saw_done = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if (done1 === 1'b1 || done2 === 1'b1) saw_done = 1'b1;
      end
      chk("abort_no_done", saw_done, 1'b0);
      run_op("after_abort", {15'o00001, 15'o00000}, 15'o00003, 15'o12525, 15'o00001, 1'b0, 16, 9, 0);

      // Random traffic, including starts issued while busy and occasional resets.
      repeat (2500) begin
         rand_ops(rn, rd);
         start = ($urandom_range(0, 3) == 0);
         numer = rn;
         denom = rd;
         reset = ($urandom_range(0, 399) == 0);
         @(negedge clock);
      end
      start = 1'b0;
      reset = 1'b0;
      repeat (40) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
